// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU constants: multiply/divide sequencer state encoding and iteration count
package cpu_pkg;

  localparam int MD_ITER = 32;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_MULT_RUN = 3'd1;
  localparam logic [2:0] S_DIV_RUN  = 3'd2;
  localparam logic [2:0] S_DIV_FIX  = 3'd3;
  localparam logic [2:0] S_DONE     = 3'd4;

  // Two's-complement magnitude; 0x80000000 maps to itself and is read as unsigned 2^31.
  function automatic logic [31:0] abs32(input logic [31:0] v);
    return v[31] ? -v : v;
  endfunction

endpackage

// File: rtl/mult_div_ctrl_if.sv
// rtl/mult_div_ctrl_if.sv - start/operand/result bundle between main control and the MULT/DIV sequencer
interface mult_div_ctrl_if;
  logic        start_mult;
  logic        start_div;
  logic [31:0] a_in;
  logic [31:0] b_in;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic [31:0] hi_out;
  logic [31:0] lo_out;
  logic        hi_write;
  logic        lo_write;

  modport master (
    output start_mult, start_div, a_in, b_in,
    input  busy, done, div_zero, hi_out, lo_out, hi_write, lo_write
  );

  modport slave (
    input  start_mult, start_div, a_in, b_in,
    output busy, done, div_zero, hi_out, lo_out, hi_write, lo_write
  );
endinterface

// File: rtl/mult_div_ctrl_div_step.sv
// rtl/mult_div_ctrl_div_step.sv - one restoring-division step: shift in a dividend bit, trial subtract, restore
module div_step (
  input  logic [31:0] rem,
  input  logic        dividend_msb,
  input  logic [31:0] divisor,
  output logic [31:0] rem_next,
  output logic        q_bit
);
  logic [32:0] shifted;
  logic [31:0] trial;

  assign shifted  = {rem, dividend_msb};
  assign q_bit    = (shifted >= {1'b0, divisor});
  assign trial    = shifted[31:0] - divisor;
  assign rem_next = q_bit ? trial : shifted[31:0];
endmodule

// File: rtl/mult_div_ctrl.sv
// rtl/mult_div_ctrl.sv - multicycle signed MULT (radix-2 Booth) / DIV (restoring) sequencer feeding HI/LO
module mult_div_ctrl
  import cpu_pkg::*;
#(
  parameter int ITER = MD_ITER
) (
  input  logic          clk,
  input  logic          reset,
  mult_div_ctrl_if.slave md
);
  localparam int CW = $clog2(ITER) + 1;

  logic [2:0]    state;
  logic [CW-1:0] count;
  logic [31:0]   acc;
  logic [31:0]   qr;
  logic [31:0]   mr;
  logic          q_m1;
  logic          sign_a;
  logic          sign_b;
  logic          dz;
  logic [31:0]   hi_q;
  logic [31:0]   lo_q;
  logic          last;
  logic          done_w;
  logic [32:0]   booth_sum;
  logic [31:0]   booth_p;
  logic [31:0]   booth_q;
  logic [31:0]   div_rem;
  logic          div_qbit;

  assign last = (count == CW'(ITER - 1));

  // The add/sub runs one bit wider than P so multiplicand 0x80000000 cannot overflow before the shift.
  always_comb begin
    booth_sum = {acc[31], acc};
    case ({qr[0], q_m1})
      2'b01:   booth_sum = {acc[31], acc} + {mr[31], mr};
      2'b10:   booth_sum = {acc[31], acc} - {mr[31], mr};
      default: booth_sum = {acc[31], acc};
    endcase
  end

  assign booth_p = booth_sum[32:1];
  assign booth_q = {booth_sum[0], qr[31:1]};

  div_step u_div_step (
    .rem          (acc),
    .dividend_msb (qr[31]),
    .divisor      (mr),
    .rem_next     (div_rem),
    .q_bit        (div_qbit)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_IDLE;
      count  <= '0;
      acc    <= '0;
      qr     <= '0;
      mr     <= '0;
      q_m1   <= 1'b0;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      dz     <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (md.start_mult) begin
            acc   <= '0;
            qr    <= md.a_in;
            mr    <= md.b_in;
            q_m1  <= 1'b0;
            count <= '0;
            dz    <= 1'b0;
            state <= S_MULT_RUN;
          end else if (md.start_div) begin
            acc    <= '0;
            qr     <= abs32(md.a_in);
            mr     <= abs32(md.b_in);
            sign_a <= md.a_in[31];
            sign_b <= md.b_in[31];
            count  <= '0;
            dz     <= (md.b_in == '0);
            state  <= (md.b_in == '0) ? S_DONE : S_DIV_RUN;
          end
        end
        S_MULT_RUN: begin
          acc   <= booth_p;
          qr    <= booth_q;
          q_m1  <= qr[0];
          count <= count + 1'b1;
          if (last) begin
            hi_q  <= booth_p;
            lo_q  <= booth_q;
            state <= S_DONE;
          end
        end
        S_DIV_RUN: begin
          acc   <= div_rem;
          qr    <= {qr[30:0], div_qbit};
          count <= count + 1'b1;
          if (last) state <= S_DIV_FIX;
        end
        S_DIV_FIX: begin
          hi_q  <= sign_a ? -acc : acc;
          lo_q  <= (sign_a ^ sign_b) ? -qr : qr;
          state <= S_DONE;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign done_w      = (state == S_DONE);
  assign md.busy     = (state != S_IDLE);
  assign md.done     = done_w;
  assign md.div_zero = done_w & dz;
  assign md.hi_write = done_w & ~dz;
  assign md.lo_write = done_w & ~dz;
  assign md.hi_out   = hi_q;
  assign md.lo_out   = lo_q;
endmodule

// File: tb/tb_mult_div_ctrl.sv
// tb/tb_mult_div_ctrl.sv - scoreboard bench for the MULT/DIV sequencer
module tb_mult_div_ctrl;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          lat;
    int          t0;
  } exp_t;

  logic clk;
  logic reset;
  int   cyc;
  int   checks;
  int   errors;
  exp_t sb[$];
  logic [31:0] last_hi;
  logic [31:0] last_lo;

  mult_div_ctrl_if md ();

  mult_div_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .md    (md)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic exp_t model(input bit is_mult, input logic [31:0] a, input logic [31:0] b);
    longint la;
    longint lb;
    longint r;
    exp_t   e;
    la    = longint'($signed(a));
    lb    = longint'($signed(b));
    e.t0  = 0;
    if (is_mult) begin
      r     = la * lb;
      e.hi  = r[63:32];
      e.lo  = r[31:0];
      e.dz  = 1'b0;
      e.lat = 33;
    end else if (b == 32'd0) begin
      e.hi  = last_hi;
      e.lo  = last_lo;
      e.dz  = 1'b1;
      e.lat = 1;
    end else begin
      r     = la / lb;
      e.lo  = r[31:0];
      r     = la % lb;
      e.hi  = r[31:0];
      e.dz  = 1'b0;
      e.lat = 34;
    end
    return e;
  endfunction

  task automatic wait_idle();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!md.busy) return;
    end
    check("idle_timeout", 64'(md.busy), 64'd0);
  endtask

  task automatic run_op(input bit is_mult, input bit is_div, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    wait_idle();
    @(negedge clk);
    md.start_mult = is_mult;
    md.start_div  = is_div;
    md.a_in       = a;
    md.b_in       = b;
    e             = model(is_mult, a, b);
    e.t0          = cyc;
    last_hi       = e.hi;
    last_lo       = e.lo;
    sb.push_back(e);
    @(negedge clk);
    md.start_mult = 1'b0;
    md.start_div  = 1'b0;
    md.a_in       = $urandom;
    md.b_in       = $urandom;
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && sb.size() != 0; i++) @(negedge clk);
    check("drain", 64'(sb.size()), 64'd0);
  endtask

  // Monitor: pops the scoreboard on every done and checks pulse width and latency.
  initial begin
    exp_t e;
    int   busy_cnt;
    bit   prev_done;
    busy_cnt  = 0;
    prev_done = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        busy_cnt  = 0;
        prev_done = 1'b0;
      end else begin
        if (md.busy) busy_cnt++;
        if (prev_done)
          check("pulse_width", {60'd0, md.done, md.hi_write, md.lo_write, md.div_zero}, 64'd0);
        if (md.done) begin
          if (sb.size() == 0) begin
            check("unexpected_done", 64'(md.done), 64'd0);
          end else begin
            e = sb.pop_front();
            check("hi_out", 64'(md.hi_out), 64'(e.hi));
            check("lo_out", 64'(md.lo_out), 64'(e.lo));
            check("div_zero", 64'(md.div_zero), 64'(e.dz));
            check("hi_write", 64'(md.hi_write), 64'(!e.dz));
            check("lo_write", 64'(md.lo_write), 64'(!e.dz));
            check("latency", 64'(cyc - e.t0), 64'(e.lat));
            check("busy_cycles", 64'(busy_cnt), 64'(e.lat));
          end
          busy_cnt = 0;
        end
        prev_done = md.done;
      end
    end
  end

  initial begin
    checks        = 0;
    errors        = 0;
    last_hi       = '0;
    last_lo       = '0;
    md.start_mult = 1'b0;
    md.start_div  = 1'b0;
    md.a_in       = '0;
    md.b_in       = '0;
    reset         = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_flags", {59'd0, md.busy, md.done, md.div_zero, md.hi_write, md.lo_write}, 64'd0);
    check("rst_hilo", {md.hi_out, md.lo_out}, 64'd0);
    reset = 1'b0;

    run_op(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD);
    run_op(1'b1, 1'b0, 32'h8000_0000, 32'h8000_0000);
    run_op(1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2);
    run_op(1'b0, 1'b1, 32'd7, 32'hFFFF_FFFE);
    run_op(1'b0, 1'b1, 32'd5, 32'd0);
    run_op(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op(1'b0, 1'b1, 32'd3, 32'hFFFF_FFF6);
    run_op(1'b1, 1'b0, 32'h7FFF_FFFF, 32'h8000_0000);
    for (int i = 0; i < 8; i++) begin
      logic [31:0] ra;
      logic [31:0] rb;
      ra = $urandom;
      rb = (i % 3 == 0) ? 32'($urandom_range(1, 100)) : $urandom;
      run_op(i[0], !i[0], ra, rb);
    end
    drain();

    // Abort a multiply 10 cycles in: no result, HI/LO cleared.
    wait_idle();
    @(negedge clk);
    md.start_mult = 1'b1;
    md.a_in       = 32'd123;
    md.b_in       = 32'd456;
    @(negedge clk);
    md.start_mult = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("abort_flags", {59'd0, md.busy, md.done, md.div_zero, md.hi_write, md.lo_write}, 64'd0);
    check("abort_hilo", {md.hi_out, md.lo_out}, 64'd0);
    reset   = 1'b0;
    last_hi = '0;
    last_lo = '0;

    // Both starts at once: multiply wins; starts while busy are dropped.
    run_op(1'b1, 1'b1, 32'd6, 32'd7);
    repeat (5) @(negedge clk);
    md.start_div = 1'b1;
    md.a_in      = 32'd100;
    md.b_in      = 32'd5;
    @(negedge clk);
    md.start_div  = 1'b0;
    repeat (5) @(negedge clk);
    md.start_mult = 1'b1;
    @(negedge clk);
    md.start_mult = 1'b0;
    drain();
    repeat (60) @(negedge clk);
    check("final_idle", 64'(md.busy), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
